joy_shift_reader: RTL and testbench
===================================

JOY_SHIFT_READER -- requirements
Module: joy_shift_reader

Interface
REQ-001 SHALL have parameter CLKDIV, default 8: clk cycles per tick; legal range 2..255.
REQ-002 SHALL have parameter GAP, default 4: idle ticks between frames; legal range 1..255.
REQ-003 SHALL have port clk  input  1  sole system clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port joy_data  input  1  serial output of the external 16-bit 74HC165 chain.
REQ-006 SHALL have port joy_clk  output  1  shift clock to the chain.
REQ-007 SHALL have port joy_load_n  output  1  parallel-load strobe to the chain, active-low.
REQ-008 SHALL have port joy1  output  6  player 1 {up,down,left,right,fire1,fire2}, active-high.
REQ-009 SHALL have port joy2  output  6  player 2, same bit order as joy1.
REQ-010 SHALL have port frame_done  output  1  one-clk pulse at the end of every frame.
REQ-011 SHALL have port joy_update  output  1  one-clk pulse when joy1/joy2 take new values.

Function
REQ-012 SHALL generate tick: an 8-bit prescaler counts 0..CLKDIV-1; tick=1 in the cycle where the count is CLKDIV-1, then the count wraps to 0.
REQ-013 SHALL advance the FSM only on tick; between ticks all state and outputs hold.
REQ-014 SHALL implement states LOAD, SHIFT_LO, SHIFT_HI, LATCH, WAIT.
REQ-015 LOAD: joy_load_n=0, joy_clk=0, lasts 1 tick; goes to SHIFT_LO with bit counter=0.
REQ-016 SHIFT_LO: joy_load_n=1, joy_clk=0; on tick, shift joy_data into sh[0] (sh shifts left, so the first bit ends up in sh[15]); goes to SHIFT_HI.
REQ-017 SHIFT_HI: joy_clk=1; on tick, increment the bit counter; if the counter was 15, go to LATCH, else go to SHIFT_LO.
REQ-018 LATCH: joy_clk=0; on tick, go to WAIT and perform the REQ-019..REQ-021 actions in that same clk cycle.
REQ-019 In LATCH: raw = {~sh[15:10], ~sh[7:2]} (12 bits); sh[9:8] and sh[1:0] are ignored.
REQ-020 In LATCH: frame_done=1 for exactly one clk; prev_raw <= raw.
REQ-021 In LATCH: if raw==prev_raw and raw!={joy1,joy2}, load {joy1,joy2}<=raw and pulse joy_update for one clk; otherwise hold outputs and keep joy_update=0.
REQ-022 WAIT: outputs idle (joy_load_n=1, joy_clk=0); after GAP ticks, go to LOAD.
REQ-023 Frame period SHALL be exactly (34+GAP)*CLKDIV clk cycles; frames repeat continuously.
REQ-024 joy_clk and joy_load_n SHALL be registered outputs (glitch-free), changing only in the clk cycle after a tick.
REQ-025 joy_data SHALL pass through a 2-flop synchronizer before sampling; sampling point = tick at the end of SHIFT_LO.

Reset
REQ-026 While rst=1: state=LOAD, prescaler=0, bit counter=0, sh=16'hFFFF, prev_raw=0, joy1=0, joy2=0, frame_done=0, joy_update=0, joy_clk=0, joy_load_n=1.
REQ-027 rst asserted mid-frame SHALL abort the frame with no frame_done and no output update; the first full frame starts at the first tick after release.
REQ-028 An update SHALL need two matching consecutive frames after reset, so a single glitch frame never reaches joy1/joy2.

Verification
REQ-029 CLKDIV=4, GAP=2, joy_data held 1 -> frame_done every 144 clks; joy1=joy2=0; joy_update never pulses.
REQ-030 Chain model drives 16'b0111_1111_1111_1111 (bit15 first) for two frames -> joy_update pulses once at the end of frame 2; joy1=6'b100000, joy2=0.
REQ-031 Model drives 16'b1111_1111_1111_1110 -> joy1=joy2=0 (ignored bit); drives 16'hFF03 -> joy2=6'b111111 after the second frame.
REQ-032 Same pattern for frames 1 and 3, a different pattern for frame 2 -> no update until two consecutive frames match.
REQ-033 Assert rst during SHIFT_HI of bit 7 -> outputs go to reset values the same cycle; no frame_done in that frame; joy_load_n=0 at the first tick after release.
REQ-034 Check each frame -> joy_load_n low for exactly CLKDIV clks; exactly 16 joy_clk rising edges; joy_clk never high while joy_load_n=0.

Source files
------------

// File: rtl/joy_shift_reader.sv
// joy_shift_reader
// Reads two 6-button joysticks through an external 16-bit 74HC165 chain.
// Each frame parallel-loads the chain, clocks out 16 bits (MSB first),
// decodes them and publishes the result only after two identical frames in a row.
//
// Ports:
//   clk        - system clock, all logic on the rising edge
//   rst        - asynchronous active-high reset
//   joy_data   - serial data from the chain (asynchronous, synchronized here)
//   joy_clk    - shift clock to the chain (registered)
//   joy_load_n - active-low parallel-load strobe to the chain (registered)
//   joy1/joy2  - {up,down,left,right,fire1,fire2}, active-high
//   frame_done - one-clk pulse at the end of each frame
//   joy_update - one-clk pulse when joy1/joy2 change
module joy_shift_reader #(
    parameter int CLKDIV = 8,   // clk cycles per tick, 2..255
    parameter int GAP    = 4    // idle ticks between frames, 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       joy_data,
    output logic       joy_clk,
    output logic       joy_load_n,
    output logic [5:0] joy1,
    output logic [5:0] joy2,
    output logic       frame_done,
    output logic       joy_update
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH,
        S_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_presc;
    logic        w_tick;
    logic [1:0]  r_sync;
    logic [3:0]  r_bitcnt;
    logic [7:0]  r_waitcnt;
    logic [15:0] r_sh;
    logic [11:0] r_prev_raw;
    logic [11:0] r_joy;
    logic [11:0] w_raw;
    logic        r_joy_clk;
    logic        r_joy_load_n;
    logic        r_frame_done;
    logic        r_joy_update;

    assign w_tick = (r_presc == 8'(CLKDIV - 1));

    // Buttons pull chain inputs low; bits 9:8 and 1:0 are unused chain inputs.
    assign w_raw = {~r_sh[15:10], ~r_sh[7:2]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            // joy_load_n still high means the strobe has not been driven yet
            // (first tick after reset): spend one full tick in LOAD first.
            S_LOAD:     w_next = r_joy_load_n ? S_LOAD : S_SHIFT_LO;
            S_SHIFT_LO: w_next = S_SHIFT_HI;
            S_SHIFT_HI: w_next = (r_bitcnt == 4'd15) ? S_LATCH : S_SHIFT_LO;
            S_LATCH:    w_next = S_WAIT;
            S_WAIT:     w_next = (r_waitcnt == 8'(GAP - 1)) ? S_LOAD : S_WAIT;
            default:    w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_LOAD;
            r_presc      <= '0;
            r_sync       <= 2'b11;
            r_bitcnt     <= '0;
            r_waitcnt    <= '0;
            r_sh         <= 16'hFFFF;
            r_prev_raw   <= '0;
            r_joy        <= '0;
            r_joy_clk    <= 1'b0;
            r_joy_load_n <= 1'b1;
            r_frame_done <= 1'b0;
            r_joy_update <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], joy_data};
            r_presc      <= w_tick ? 8'd0 : r_presc + 8'd1;
            r_frame_done <= 1'b0;
            r_joy_update <= 1'b0;
            if (w_tick) begin
                r_state      <= w_next;
                // Pins follow the state being entered, so they hold a full tick.
                r_joy_load_n <= (w_next != S_LOAD);
                r_joy_clk    <= (w_next == S_SHIFT_HI);
                case (r_state)
                    S_LOAD:     r_bitcnt <= '0;
                    S_SHIFT_LO: r_sh <= {r_sh[14:0], r_sync[1]};
                    S_SHIFT_HI: r_bitcnt <= r_bitcnt + 4'd1;
                    S_LATCH: begin
                        r_frame_done <= 1'b1;
                        r_prev_raw   <= w_raw;
                        r_waitcnt    <= '0;
                        // Debounce: publish only a value seen in two consecutive frames.
                        if (w_raw == r_prev_raw && w_raw != r_joy) begin
                            r_joy        <= w_raw;
                            r_joy_update <= 1'b1;
                        end
                    end
                    S_WAIT:     r_waitcnt <= r_waitcnt + 8'd1;
                    default:    r_bitcnt <= '0;
                endcase
            end
        end
    end

    assign joy_clk    = r_joy_clk;
    assign joy_load_n = r_joy_load_n;
    assign joy1       = r_joy[11:6];
    assign joy2       = r_joy[5:0];
    assign frame_done = r_frame_done;
    assign joy_update = r_joy_update;

endmodule

// File: tb/tb_joy_shift_reader.sv
// Bench for joy_shift_reader: a 74HC165 chain model feeds table-driven frame
// patterns; expected per-frame results go through a scoreboard queue and are
// compared at each frame_done, together with per-frame pin timing counts.
module tb_joy_shift_reader;

    localparam int CLKDIV = 4;
    localparam int GAP    = 2;
    localparam int PERIOD = (34 + GAP) * CLKDIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       joy_data;
    logic       joy_clk, joy_load_n, frame_done, joy_update;
    logic [5:0] joy1, joy2;

    joy_shift_reader #(.CLKDIV(CLKDIV), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .joy_data(joy_data),
        .joy_clk(joy_clk), .joy_load_n(joy_load_n),
        .joy1(joy1), .joy2(joy2),
        .frame_done(frame_done), .joy_update(joy_update)
    );

    always #5 clk = ~clk;

    // Chain model: async parallel load on load_n falling, shift on joy_clk rising.
    logic [15:0] cur_pat = 16'hFFFF;
    logic [15:0] sr = 16'hFFFF;
    always @(posedge joy_clk or negedge joy_load_n) begin
        if (!joy_load_n) sr <= cur_pat;
        else             sr <= {sr[14:0], 1'b1};
    end
    assign joy_data = sr[15];

    typedef struct {
        logic [15:0] pat;
        logic        upd;
        logic [5:0]  j1;
        logic [5:0]  j2;
    } vec_t;

    vec_t tbl[12];
    vec_t sb[$];
    vec_t e;

    int n_cmp = 0;
    int n_bad = 0;

    // Pin monitor, sampled on the falling edge.
    int ld_cnt = 0, rise_cnt = 0, ovl = 0, cyc = 0, upd_total = 0;
    int snap_ld = 0, snap_rise = 0, snap_ovl = 0, snap_cyc = 0;
    logic prev_jc = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (joy_update) upd_total++;
        if (rst) begin
            ld_cnt = 0; rise_cnt = 0; ovl = 0; prev_jc = 1'b0;
        end else begin
            if (!joy_load_n) ld_cnt++;
            if (joy_clk && !prev_jc) rise_cnt++;
            if (joy_clk && !joy_load_n) ovl++;
            prev_jc = joy_clk;
            if (frame_done) begin
                snap_ld = ld_cnt; snap_rise = rise_cnt; snap_ovl = ovl; snap_cyc = cyc;
                ld_cnt = 0; rise_cnt = 0; ovl = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 4 * PERIOD; n++) begin
            @(negedge clk);
            if (frame_done) begin ok = 1'b1; break; end
        end
        #1;
    endtask

    // Pops the scoreboard and checks the frame that just ended.
    task automatic check_frame(input string tag);
        e = sb.pop_front();
        check({tag, " joy_update"}, 32'(joy_update), 32'(e.upd));
        check({tag, " joy1"}, 32'(joy1), 32'(e.j1));
        check({tag, " joy2"}, 32'(joy2), 32'(e.j2));
        check({tag, " load_n low clks"}, 32'(snap_ld), 32'(CLKDIV));
        check({tag, " joy_clk rises"}, 32'(snap_rise), 32'd16);
        check({tag, " clk while load"}, 32'(snap_ovl), 32'd0);
    endtask

    initial begin
        bit ok;
        int exp_upd;
        int last_cyc;

        tbl[0]  = '{16'hFFFF, 1'b0, 6'h00, 6'h00};
        tbl[1]  = '{16'hFFFF, 1'b0, 6'h00, 6'h00};
        tbl[2]  = '{16'h7FFF, 1'b0, 6'h00, 6'h00};
        tbl[3]  = '{16'h7FFF, 1'b1, 6'h20, 6'h00};
        tbl[4]  = '{16'hFFFE, 1'b0, 6'h20, 6'h00};
        tbl[5]  = '{16'hFFFE, 1'b1, 6'h00, 6'h00};
        tbl[6]  = '{16'hFF03, 1'b0, 6'h00, 6'h00};
        tbl[7]  = '{16'hFF03, 1'b1, 6'h00, 6'h3F};
        tbl[8]  = '{16'h7FFF, 1'b0, 6'h00, 6'h3F};
        tbl[9]  = '{16'hBFFF, 1'b0, 6'h00, 6'h3F};
        tbl[10] = '{16'h7FFF, 1'b0, 6'h00, 6'h3F};
        tbl[11] = '{16'h7FFF, 1'b1, 6'h20, 6'h00};
        exp_upd = 0;
        last_cyc = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst joy_load_n", 32'(joy_load_n), 32'd1);
        check("rst joy_clk", 32'(joy_clk), 32'd0);
        check("rst joy1", 32'(joy1), 32'd0);
        check("rst joy2", 32'(joy2), 32'd0);
        check("rst frame_done", 32'(frame_done), 32'd0);
        check("rst joy_update", 32'(joy_update), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            cur_pat = tbl[i].pat;
            sb.push_back(tbl[i]);
            if (tbl[i].upd) exp_upd++;
            wait_frame(ok);
            if (!ok) begin
                check($sformatf("frame %0d timeout", i), 32'd0, 32'd1);
                void'(sb.pop_front());
            end else begin
                check_frame($sformatf("frame %0d", i));
                if (i > 0) check($sformatf("frame %0d period", i), 32'(snap_cyc - last_cyc), 32'(PERIOD));
                last_cyc = snap_cyc;
            end
        end

        // Reset mid-frame, during the high phase of bit 7.
        ok = 1'b0;
        for (int n = 0; n < 2 * PERIOD; n++) begin
            @(negedge clk);
            if (rise_cnt == 8 && joy_clk) begin ok = 1'b1; break; end
        end
        check("reach bit7 SHIFT_HI", 32'(ok), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst joy1", 32'(joy1), 32'd0);
        check("midrst joy2", 32'(joy2), 32'd0);
        check("midrst joy_clk", 32'(joy_clk), 32'd0);
        check("midrst joy_load_n", 32'(joy_load_n), 32'd1);
        repeat (2) begin
            @(negedge clk);
            check("midrst frame_done", 32'(frame_done), 32'd0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post-rst load_n before tick", 32'(joy_load_n), 32'd1);
        @(negedge clk);
        check("post-rst load_n at first tick", 32'(joy_load_n), 32'd0);

        // Two matching frames are needed again after reset.
        cur_pat = 16'h7FFF;
        sb.push_back('{16'h7FFF, 1'b0, 6'h00, 6'h00});
        wait_frame(ok);
        if (!ok) begin check("post-rst frame A timeout", 32'd0, 32'd1); void'(sb.pop_front()); end
        else check_frame("post-rst frame A");
        sb.push_back('{16'h7FFF, 1'b1, 6'h20, 6'h00});
        exp_upd++;
        wait_frame(ok);
        if (!ok) begin check("post-rst frame B timeout", 32'd0, 32'd1); void'(sb.pop_front()); end
        else check_frame("post-rst frame B");

        check("total joy_update pulses", 32'(upd_total), 32'(exp_upd));
        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
